// File: rtl/event_collect_8to1.sv
// Collects eight asynchronous event lines into one valid/ready stream of channel indices.
// Events are synchronised, edge- or level-detected, held as pending flags, and granted round-robin.
module event_collect_8to1 #(
   parameter int SYNC_STAGES = 2,
   parameter int EDGE_DETECT = 1,
   parameter int OVF_W       = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in0,
   input  logic             in1,
   input  logic             in2,
   input  logic             in3,
   input  logic             in4,
   input  logic             in5,
   input  logic             in6,
   input  logic             in7,
   input  logic             out_ready,
   input  logic             clr_ovf,
   output logic             out_valid,
   output logic [2:0]       out_sel,
   output logic [7:0]       pending,
   output logic [OVF_W-1:0] overflow_cnt
);

   // state   | meaning
   // IDLE    | nothing presented; pick next pending channel round-robin
   // PRESENT | out_sel presented with out_valid=1 until out_ready
   typedef enum logic {IDLE, PRESENT} state_t;

   state_t           state_q, state_d;
   logic [7:0]       in_vec, synced, prev_q, evt, clear, lost;
   logic [7:0]       pending_q, pending_d;
   logic [7:0]       sync_q [SYNC_STAGES];
   logic [2:0]       sel_q, sel_d, last_grant_q, last_grant_d, pick, idx;
   logic             found;
   logic [OVF_W-1:0] ovf_q;

   assign in_vec = {in7, in6, in5, in4, in3, in2, in1, in0};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
         prev_q <= '0;
      end else begin
         sync_q[0] <= in_vec;
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
         prev_q <= synced;
      end
   end

   assign synced = sync_q[SYNC_STAGES-1];
   assign evt    = (EDGE_DETECT != 0) ? (synced & ~prev_q) : synced;

   // A set landing on the clearing handshake wins, so the event is kept rather than lost.
   assign clear     = (state_q == PRESENT && out_ready) ? (8'b1 << sel_q) : 8'b0;
   assign pending_d = (pending_q & ~clear) | evt;
   assign lost      = (EDGE_DETECT != 0) ? (evt & pending_q & ~clear) : 8'b0;

   always_comb begin
      pick  = last_grant_q;
      found = 1'b0;
      idx   = '0;
      for (int k = 1; k <= 8; k++) begin
         idx = last_grant_q + 3'(k);
         if (!found && pending_q[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      last_grant_d = last_grant_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               sel_d   = pick;
               state_d = PRESENT;
            end
         end
         PRESENT: begin
            if (out_ready) begin
               last_grant_d = sel_q;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         sel_q        <= '0;
         last_grant_q <= 3'd7;
         pending_q    <= '0;
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         last_grant_q <= last_grant_d;
         pending_q    <= pending_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= '0;
      end else if (clr_ovf) begin
         ovf_q <= '0;
      end else if ((|lost) && !(&ovf_q)) begin
         ovf_q <= ovf_q + 1'b1;
      end
   end

   assign out_valid    = (state_q == PRESENT);
   assign out_sel      = sel_q;
   assign pending      = pending_q;
   assign overflow_cnt = ovf_q;

endmodule
